// File: rtl/ammo_launcher_if.sv
// Projectile bus between the ammo launcher (master) and the obstacle block (slave).
// The launcher drives position/size; the obstacle block returns a registered hit pulse.
interface ammo_launcher_if;
  logic [9:0] ball_ammo_x;
  logic [9:0] ball_ammo_y;
  logic [9:0] ball_ammo_size;
  logic       bullet_hit;

  modport master (
    output ball_ammo_x,
    output ball_ammo_y,
    output ball_ammo_size,
    input  bullet_hit
  );

  modport slave (
    input  ball_ammo_x,
    input  ball_ammo_y,
    input  ball_ammo_size,
    output bullet_hit
  );
endinterface

// File: rtl/ammo_launcher.sv
// Player projectile source: launches on a fire edge, climbs once per frame, retires on hit/top,
// then paces the next shot. Define AMMO_RELOAD_EN to enable the magazine and RELOAD state.
module ammo_launcher #(
  parameter int BULLET_SPEED  = 8,
  parameter int BULLET_SIZE   = 4,
  parameter int Y_TOP         = 3,
  parameter int COOLDOWN      = 10,
  parameter int MAG_SIZE      = 6,
  parameter int RELOAD_FRAMES = 60
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic                  fire,
  input  logic                  game_over,
  input  logic                  start_screen,
  input  logic [9:0]            ship_x,
  input  logic [9:0]            ship_y,
  ammo_launcher_if.master       ammo_bus,
  output logic                  ammo_active,
  output logic [3:0]            ammo_left,
  output logic                  shot_fired
);

  localparam logic [9:0] LAUNCH_MIN = 10'(Y_TOP + BULLET_SIZE);
  localparam logic [9:0] TOP_LIMIT  = 10'(Y_TOP + BULLET_SPEED);
  localparam logic [9:0] SPEED      = 10'(BULLET_SPEED);
  localparam logic [9:0] SIZE       = 10'(BULLET_SIZE);
  // A zero cooldown still costs one frame before READY.
  localparam logic [9:0] COOL_LOAD  = (COOLDOWN == 0) ? 10'd0 : 10'(COOLDOWN - 1);
  localparam logic [3:0] MAG        = 4'(MAG_SIZE);

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_FLIGHT   = 2'd1,
    ST_COOLDOWN = 2'd2
`ifdef AMMO_RELOAD_EN
    ,ST_RELOAD  = 2'd3
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [9:0] cnt_q, cnt_d;
  logic       active_q, active_d;
  logic       shot_q, shot_d;
  logic       fire_q, fire_d;
  logic       launch_req;
  logic       have_ammo;

`ifdef AMMO_RELOAD_EN
  localparam logic [9:0] RELOAD_LOAD = (RELOAD_FRAMES == 0) ? 10'd0 : 10'(RELOAD_FRAMES - 1);
  logic [3:0] ammo_q, ammo_d;
  assign have_ammo = (ammo_q != 4'd0);
  assign ammo_left = ammo_q;
`else
  assign have_ammo = 1'b1;
  assign ammo_left = MAG;
`endif

  assign launch_req = fire & ~fire_q;

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_READY;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      shot_q   <= 1'b0;
      fire_q   <= 1'b0;
`ifdef AMMO_RELOAD_EN
      ammo_q   <= MAG;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      shot_q   <= shot_d;
      fire_q   <= fire_d;
`ifdef AMMO_RELOAD_EN
      ammo_q   <= ammo_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    shot_d   = 1'b0;
    fire_d   = fire;
`ifdef AMMO_RELOAD_EN
    ammo_d   = ammo_q;
`endif
    if (game_over || start_screen) begin
      state_d  = ST_READY;
      x_d      = '0;
      y_d      = '0;
      cnt_d    = '0;
      active_d = 1'b0;
      fire_d   = 1'b0;
`ifdef AMMO_RELOAD_EN
      ammo_d   = MAG;
`endif
    end else begin
      case (state_q)
        ST_READY: begin
          if (launch_req && (ship_y >= LAUNCH_MIN) && have_ammo) begin
            state_d  = ST_FLIGHT;
            x_d      = ship_x;
            y_d      = ship_y - SIZE;
            active_d = 1'b1;
            shot_d   = 1'b1;
`ifdef AMMO_RELOAD_EN
            ammo_d   = ammo_q - 4'd1;
`endif
          end
        end
        ST_FLIGHT: begin
          // Compare before subtracting so the projectile never wraps past the top.
          if (ammo_bus.bullet_hit || (y_q < TOP_LIMIT)) begin
            x_d      = '0;
            y_d      = '0;
            active_d = 1'b0;
            state_d  = ST_COOLDOWN;
            cnt_d    = COOL_LOAD;
`ifdef AMMO_RELOAD_EN
            if (ammo_q == 4'd0) begin
              state_d = ST_RELOAD;
              cnt_d   = RELOAD_LOAD;
            end
`endif
          end else begin
            y_d = y_q - SPEED;
          end
        end
        ST_COOLDOWN: begin
          if (cnt_q == 10'd0) state_d = ST_READY;
          else                cnt_d   = cnt_q - 10'd1;
        end
`ifdef AMMO_RELOAD_EN
        ST_RELOAD: begin
          if (cnt_q == 10'd0) begin
            state_d = ST_READY;
            ammo_d  = MAG;
          end else begin
            cnt_d = cnt_q - 10'd1;
          end
        end
`endif
        default: state_d = ST_READY;
      endcase
    end
  end

  assign ammo_bus.ball_ammo_x    = x_q;
  assign ammo_bus.ball_ammo_y    = y_q;
  assign ammo_bus.ball_ammo_size = SIZE;
  assign ammo_active             = active_q;
  assign shot_fired              = shot_q;

endmodule

// File: tb/tb_ammo_launcher.sv
// Directed bench for ammo_launcher: launch, hit, top retire, cooldown timing, held fire,
// launch bound, sync/async clears and (with AMMO_RELOAD_EN) the magazine reload.
module tb_ammo_launcher;
  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       fire, game_over, start_screen;
  logic [9:0] ship_x, ship_y;
  logic       ammo_active, shot_fired;
  logic [3:0] ammo_left;
  int         n_checks = 0;
  int         n_fail   = 0;

  ammo_launcher_if bus ();

  ammo_launcher dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .fire         (fire),
    .game_over    (game_over),
    .start_screen (start_screen),
    .ship_x       (ship_x),
    .ship_y       (ship_y),
    .ammo_bus     (bus),
    .ammo_active  (ammo_active),
    .ammo_left    (ammo_left),
    .shot_fired   (shot_fired)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; fire = 1'b0; game_over = 1'b0; start_screen = 1'b0;
    ship_x = 10'd0; ship_y = 10'd0; bus.bullet_hit = 1'b0;
    step(2);
    n_checks++; if (bus.ball_ammo_x !== 10'd0) begin n_fail++; $display("FAIL reset_x got %0d want 0", bus.ball_ammo_x); end
    n_checks++; if (bus.ball_ammo_y !== 10'd0) begin n_fail++; $display("FAIL reset_y got %0d want 0", bus.ball_ammo_y); end
    n_checks++; if (ammo_active !== 1'b0 || shot_fired !== 1'b0) begin n_fail++; $display("FAIL reset_flags got active=%b shot=%b want 0/0", ammo_active, shot_fired); end
    n_checks++; if (ammo_left !== 4'd6) begin n_fail++; $display("FAIL reset_ammo got %0d want 6", ammo_left); end
    n_checks++; if (bus.ball_ammo_size !== 10'd4) begin n_fail++; $display("FAIL size got %0d want 4", bus.ball_ammo_size); end
    Reset_n = 1'b1;
    step(1);
    $display("reset released: x=%0d y=%0d ammo_left=%0d", bus.ball_ammo_x, bus.ball_ammo_y, ammo_left);
  endtask

  task automatic test_launch_and_hit;
    bit found = 0;
    ship_x = 10'd300; ship_y = 10'd400; fire = 1'b1;
    step(1);
    $display("launch: x=%0d y=%0d active=%b shot=%b", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active, shot_fired);
    n_checks++; if (bus.ball_ammo_x !== 10'd300 || bus.ball_ammo_y !== 10'd396) begin n_fail++; $display("FAIL launch_pos got (%0d,%0d) want (300,396)", bus.ball_ammo_x, bus.ball_ammo_y); end
    n_checks++; if (ammo_active !== 1'b1 || shot_fired !== 1'b1) begin n_fail++; $display("FAIL launch_flags got active=%b shot=%b want 1/1", ammo_active, shot_fired); end
    step(1);
    n_checks++; if (bus.ball_ammo_y !== 10'd388 || shot_fired !== 1'b0) begin n_fail++; $display("FAIL flight1 got y=%0d shot=%b want 388/0", bus.ball_ammo_y, shot_fired); end
    step(1);
    n_checks++; if (bus.ball_ammo_y !== 10'd380 || bus.ball_ammo_x !== 10'd300) begin n_fail++; $display("FAIL flight2 got (%0d,%0d) want (300,380)", bus.ball_ammo_x, bus.ball_ammo_y); end
    for (int i = 0; i < 20 && !found; i++) begin
      step(1);
      if (bus.ball_ammo_y == 10'd300) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL reach_300 got y=%0d want 300 within 20 frames", bus.ball_ammo_y); end
    bus.bullet_hit = 1'b1; fire = 1'b0;
    step(1);
    bus.bullet_hit = 1'b0;
    $display("hit retire: x=%0d y=%0d active=%b", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active);
    n_checks++; if (bus.ball_ammo_x !== 10'd0 || bus.ball_ammo_y !== 10'd0 || ammo_active !== 1'b0) begin n_fail++; $display("FAIL hit_retire got (%0d,%0d) active=%b want (0,0) 0", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active); end
    step(9);
    fire = 1'b1;
    step(1);
    n_checks++; if (shot_fired !== 1'b0 || ammo_active !== 1'b0) begin n_fail++; $display("FAIL cooldown_drop got shot=%b active=%b want 0/0", shot_fired, ammo_active); end
    fire = 1'b0;
    step(1);
  endtask

  task automatic test_top_retire;
    ship_x = 10'd100; ship_y = 10'd24; fire = 1'b1;
    step(1);
    n_checks++; if (bus.ball_ammo_y !== 10'd20 || shot_fired !== 1'b1) begin n_fail++; $display("FAIL top_launch got y=%0d shot=%b want 20/1", bus.ball_ammo_y, shot_fired); end
    fire = 1'b0;
    step(1);
    n_checks++; if (bus.ball_ammo_y !== 10'd12) begin n_fail++; $display("FAIL top_y12 got %0d want 12", bus.ball_ammo_y); end
    step(1);
    n_checks++; if (bus.ball_ammo_y !== 10'd4 || ammo_active !== 1'b1) begin n_fail++; $display("FAIL top_y4 got y=%0d active=%b want 4/1", bus.ball_ammo_y, ammo_active); end
    step(1);
    $display("top retire: y=%0d active=%b", bus.ball_ammo_y, ammo_active);
    n_checks++; if (bus.ball_ammo_y !== 10'd0 || ammo_active !== 1'b0) begin n_fail++; $display("FAIL top_retire got y=%0d active=%b want 0/0", bus.ball_ammo_y, ammo_active); end
    step(10);
    fire = 1'b1;
    step(1);
    n_checks++; if (shot_fired !== 1'b1 || bus.ball_ammo_y !== 10'd20) begin n_fail++; $display("FAIL ready_after_10 got shot=%b y=%0d want 1/20", shot_fired, bus.ball_ammo_y); end
    fire = 1'b0;
  endtask

  task automatic test_held_fire;
    int shots = 0;
    step(20);
    fire = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (shot_fired === 1'b1) shots++;
    end
    fire = 1'b0;
    $display("held fire 50 frames: shots=%0d", shots);
    n_checks++; if (shots !== 1) begin n_fail++; $display("FAIL held_fire got %0d shots want 1", shots); end
    step(20);
  endtask

  task automatic test_launch_bound;
    ship_x = 10'd50; ship_y = 10'd6; fire = 1'b1;
    step(1);
    n_checks++; if (shot_fired !== 1'b0 || ammo_active !== 1'b0) begin n_fail++; $display("FAIL low_ship got shot=%b active=%b want 0/0", shot_fired, ammo_active); end
    fire = 1'b0;
    step(1);
    // Hit in READY is ignored; the launch still happens at the exact bound.
    ship_y = 10'd7; fire = 1'b1; bus.bullet_hit = 1'b1;
    step(1);
    $display("bound launch: x=%0d y=%0d shot=%b", bus.ball_ammo_x, bus.ball_ammo_y, shot_fired);
    n_checks++; if (shot_fired !== 1'b1 || bus.ball_ammo_y !== 10'd3 || bus.ball_ammo_x !== 10'd50) begin n_fail++; $display("FAIL bound_launch got shot=%b (%0d,%0d) want 1 (50,3)", shot_fired, bus.ball_ammo_x, bus.ball_ammo_y); end
    step(1);
    bus.bullet_hit = 1'b0; fire = 1'b0;
    n_checks++; if (ammo_active !== 1'b0 || bus.ball_ammo_y !== 10'd0) begin n_fail++; $display("FAIL hit_and_top got active=%b y=%0d want 0/0", ammo_active, bus.ball_ammo_y); end
    step(12);
  endtask

  task automatic test_clears;
    ship_x = 10'd200; ship_y = 10'd400; fire = 1'b1;
    step(1);
    fire = 1'b0;
    step(3);
    n_checks++; if (bus.ball_ammo_y !== 10'd372) begin n_fail++; $display("FAIL pre_gameover got y=%0d want 372", bus.ball_ammo_y); end
    game_over = 1'b1;
    step(1);
    game_over = 1'b0;
    $display("game_over: x=%0d y=%0d active=%b ammo_left=%0d", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active, ammo_left);
    n_checks++; if (bus.ball_ammo_x !== 10'd0 || bus.ball_ammo_y !== 10'd0 || ammo_active !== 1'b0 || ammo_left !== 4'd6) begin n_fail++; $display("FAIL game_over got (%0d,%0d) active=%b ammo=%0d want (0,0) 0 6", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active, ammo_left); end
    fire = 1'b1;
    step(1);
    n_checks++; if (shot_fired !== 1'b1 || bus.ball_ammo_y !== 10'd396) begin n_fail++; $display("FAIL ready_after_clear got shot=%b y=%0d want 1/396", shot_fired, bus.ball_ammo_y); end
    fire = 1'b0;
    step(2);
    start_screen = 1'b1;
    step(1);
    start_screen = 1'b0;
    n_checks++; if (ammo_active !== 1'b0 || bus.ball_ammo_y !== 10'd0) begin n_fail++; $display("FAIL start_screen got active=%b y=%0d want 0/0", ammo_active, bus.ball_ammo_y); end
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    n_checks++; if (ammo_active !== 1'b1) begin n_fail++; $display("FAIL relaunch got active=%b want 1", ammo_active); end
    #2 Reset_n = 1'b0;
    #1;
    $display("async reset: x=%0d y=%0d active=%b", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active);
    n_checks++; if (bus.ball_ammo_x !== 10'd0 || bus.ball_ammo_y !== 10'd0 || ammo_active !== 1'b0) begin n_fail++; $display("FAIL async_reset got (%0d,%0d) active=%b want (0,0) 0", bus.ball_ammo_x, bus.ball_ammo_y, ammo_active); end
    #1 Reset_n = 1'b1;
    step(1);
  endtask

`ifdef AMMO_RELOAD_EN
  task automatic test_reload;
    ship_x = 10'd60; ship_y = 10'd7;
    for (int i = 0; i < 6; i++) begin
      fire = 1'b1;
      step(1);
      $display("mag shot %0d: shot=%b ammo_left=%0d", i + 1, shot_fired, ammo_left);
      n_checks++; if (shot_fired !== 1'b1 || ammo_left !== 4'(5 - i)) begin n_fail++; $display("FAIL mag_shot%0d got shot=%b ammo=%0d want 1/%0d", i + 1, shot_fired, ammo_left, 5 - i); end
      fire = 1'b0;
      step(1);
      if (i < 5) step(10);
    end
    step(58);
    fire = 1'b1;
    step(1);
    n_checks++; if (shot_fired !== 1'b0 || ammo_left !== 4'd0) begin n_fail++; $display("FAIL reload_hold got shot=%b ammo=%0d want 0/0", shot_fired, ammo_left); end
    fire = 1'b0;
    step(1);
    n_checks++; if (ammo_left !== 4'd6) begin n_fail++; $display("FAIL reload_done got ammo=%0d want 6", ammo_left); end
    fire = 1'b1;
    step(1);
    fire = 1'b0;
    n_checks++; if (shot_fired !== 1'b1 || ammo_left !== 4'd5) begin n_fail++; $display("FAIL shot7 got shot=%b ammo=%0d want 1/5", shot_fired, ammo_left); end
  endtask
`endif

  initial begin
    test_reset();
    test_launch_and_hit();
    test_top_retire();
    test_held_fire();
    test_launch_bound();
    test_clears();
`ifdef AMMO_RELOAD_EN
    test_reload();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
